// File: rtl/switch_led_pkg.sv
// rtl/switch_led_pkg.sv - shared display-mode encoding for switch_led_ctrl
package switch_led_pkg;

  localparam int LED_MODE_W = 2;

  typedef enum logic [LED_MODE_W-1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_INVERT = 2'b11
  } led_mode_e;

endpackage

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - one switch channel: 2-FF synchroniser, debounce counter, rise pulse
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic sw_stable,
  output logic sw_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      cnt       <= '0;
      sw_stable <= 1'b0;
      stable_q  <= 1'b0;
      sw_rise   <= 1'b0;
    end else begin
      meta <= sw_in;
      sync <= meta;
      // Any cycle that agrees with the accepted level restarts the count.
      if (sync != sw_stable) begin
        if (cnt == CNT_MAX) begin
          sw_stable <= sync;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      stable_q <= sw_stable;
      sw_rise  <= sw_stable & ~stable_q;
    end
  end

endmodule

// File: rtl/switch_led_ctrl.sv
// rtl/switch_led_ctrl.sv - multi-channel debounced switch to LED controller
// Optional blink phase generator built when SWITCH_LED_BLINK_EN is defined.
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int NUM_CH            = 4,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int BLINK_HALF_PERIOD = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     sw_in,
  input  logic [LED_MODE_W-1:0] mode,
  output logic [NUM_CH-1:0]     sw_stable,
  output logic [NUM_CH-1:0]     sw_rise,
  output logic [NUM_CH-1:0]     led
);

  logic [NUM_CH-1:0] stable_q;
  logic [NUM_CH-1:0] tog;
  logic [NUM_CH-1:0] led_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_in    (sw_in[i]),
      .sw_stable(sw_stable[i]),
      .sw_rise  (sw_rise[i])
    );
  end

  // tog flips on the same edge that the debouncer registers its rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      tog      <= '0;
    end else begin
      stable_q <= sw_stable;
      tog      <= tog ^ (sw_stable & ~stable_q);
    end
  end

`ifdef SWITCH_LED_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF_PERIOD - 1);

  logic [BW-1:0] blink_cnt;
  logic          phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    led_next = sw_stable;
    case (led_mode_e'(mode))
      MODE_DIRECT: led_next = sw_stable;
      MODE_TOGGLE: led_next = tog;
`ifdef SWITCH_LED_BLINK_EN
      MODE_BLINK:  led_next = sw_stable & {NUM_CH{phase}};
`else
      MODE_BLINK:  led_next = sw_stable;
`endif
      MODE_INVERT: led_next = ~sw_stable;
      default:     led_next = sw_stable;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_switch_led_ctrl.sv
// tb/tb_switch_led_ctrl.sv - directed self-checking bench for switch_led_ctrl
module tb_switch_led_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_in = 4'b0000;
  logic [1:0] mode = 2'b00;
  logic [3:0] sw_stable;
  logic [3:0] sw_rise;
  logic [3:0] led;

  int errors = 0;
  int checks = 0;

  switch_led_ctrl #(
    .NUM_CH           (4),
    .DEBOUNCE_CYCLES  (4),
    .BLINK_HALF_PERIOD(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_in    (sw_in),
    .mode     (mode),
    .sw_stable(sw_stable),
    .sw_rise  (sw_rise),
    .led      (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic [1:0] md;
    logic [3:0] st;
    logic [3:0] rs;
    logic [3:0] ld;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic [3:0] sw, input logic [3:0] st, input logic [3:0] rs,
                     input logic [3:0] ld);
    vec_t v;
    v.sw = sw; v.md = 2'b00; v.st = st; v.rs = rs; v.ld = ld;
    tbl.push_back(v);
  endtask

  // Press ch2 in TOGGLE mode; rise at +6, led follows at +7, then release.
  task automatic press_ch2(input logic old_t, input logic new_t);
    sw_in[2] = 1'b1;
    for (int s = 0; s < 8; s++) begin
      step();
      if (s == 6) begin
        chk("tog_rise2", {3'b0, sw_rise[2]}, 4'b0001);
        chk("tog_led_before", {3'b0, led[2]}, {3'b0, old_t});
      end
      if (s == 7) chk("tog_led_after", {3'b0, led[2]}, {3'b0, new_t});
    end
    sw_in[2] = 1'b0;
    for (int s = 0; s < 8; s++) step();
  endtask

  initial begin
    logic [3:0] exp_b;

    // Clean press on ch0, DIRECT.
    for (int i = 0; i < 5; i++) add(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0001, 4'b0001, 4'b0001);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0001);
    // 3-cycle bounce on ch1 is rejected.
    for (int i = 0; i < 3; i++) add(4'b0011, 4'b0001, 4'b0000, 4'b0001);
    for (int i = 0; i < 6; i++) add(4'b0001, 4'b0001, 4'b0000, 4'b0001);
    // 4-cycle pulse on ch1 is accepted, then released.
    for (int i = 0; i < 4; i++) add(4'b0011, 4'b0001, 4'b0000, 4'b0001);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0001);
    add(4'b0001, 4'b0011, 4'b0000, 4'b0001);
    add(4'b0001, 4'b0011, 4'b0010, 4'b0011);
    add(4'b0001, 4'b0011, 4'b0000, 4'b0011);
    add(4'b0001, 4'b0011, 4'b0000, 4'b0011);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0011);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0001);

    @(negedge clk);
    #1;
    chk("reset_stable", sw_stable, 4'b0000);
    chk("reset_rise", sw_rise, 4'b0000);
    chk("reset_led", led, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("idle_stable", sw_stable, 4'b0000);
    chk("idle_led", led, 4'b0000);

    foreach (tbl[i]) begin
      sw_in = tbl[i].sw;
      mode  = tbl[i].md;
      step();
      chk($sformatf("vec%0d_stable", i), sw_stable, tbl[i].st);
      chk($sformatf("vec%0d_rise", i), sw_rise, tbl[i].rs);
      chk($sformatf("vec%0d_led", i), led, tbl[i].ld);
    end

    // Toggle: three presses on ch2, then DIRECT and back keeps the state.
    mode = 2'b01;
    step();
    press_ch2(1'b0, 1'b1);
    press_ch2(1'b1, 1'b0);
    press_ch2(1'b0, 1'b1);
    mode = 2'b00;
    step();
    step();
    chk("direct_led2", {3'b0, led[2]}, 4'b0000);
    mode = 2'b01;
    step();
    chk("toggle_kept_led2", {3'b0, led[2]}, 4'b0001);

    // Invert with all four channels rising together.
    mode  = 2'b11;
    sw_in = 4'b0000;
    for (int i = 0; i < 8; i++) step();
    chk("inv_idle_stable", sw_stable, 4'b0000);
    chk("inv_idle_led", led, 4'b1111);
    sw_in = 4'b1111;
    for (int s = 0; s < 8; s++) begin
      step();
      if (s == 5) begin
        chk("inv_stable_up", sw_stable, 4'b1111);
        chk("inv_led_hold", led, 4'b1111);
      end
      if (s == 6) begin
        chk("inv_led_flip", led, 4'b0000);
        chk("inv_rise_all", sw_rise, 4'b1111);
      end
      if (s == 7) chk("inv_rise_end", sw_rise, 4'b0000);
    end

    // Reset in the middle of a debounce with led=1111.
    sw_in = 4'b0000;
    for (int i = 0; i < 8; i++) step();
    sw_in = 4'b1111;
    for (int s = 0; s < 5; s++) step();
    chk("pre_rst_led", led, 4'b1111);
    chk("pre_rst_stable", sw_stable, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stable", sw_stable, 4'b0000);
    chk("mid_rst_rise", sw_rise, 4'b0000);
    chk("mid_rst_led", led, 4'b0000);
    step();
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 5) chk("post_rst_stable_early", sw_stable, 4'b0000);
      if (e == 6) chk("post_rst_stable", sw_stable, 4'b1111);
      if (e == 7) chk("post_rst_rise", sw_rise, 4'b1111);
    end

    // Blink on ch3 measured from reset release.
    rst_n = 1'b0;
    sw_in = 4'b1000;
    mode  = 2'b10;
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e < 7) begin
        exp_b = 4'b0000;
      end else begin
`ifdef SWITCH_LED_BLINK_EN
        exp_b = {3'b0, 1'(((e - 1) / 8) % 2)};
`else
        exp_b = 4'b0001;
`endif
      end
      chk($sformatf("blink_e%0d", e), {3'b0, led[3]}, exp_b);
      if (e == 7) chk("blink_rise3", sw_rise, 4'b1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
